// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit PDM microphone stream: ORDER pipelined integrators
// running on the pdm_en strobe, decimation by 2^DEC_LOG2, and ORDER comb stages on clk.
module cic_decimator #(
    parameter int ORDER    = 4,
    parameter int DEC_LOG2 = 4,
    parameter int OUT_W    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_en,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] y_out,
    output logic             y_valid
);

    logic [OUT_W-1:0]    integ [ORDER];
    logic [OUT_W-1:0]    comb_q [ORDER];
    logic [OUT_W-1:0]    comb_d [ORDER];
    logic [ORDER-1:0]    comb_vld;
    logic [DEC_LOG2-1:0] cnt;
    logic [OUT_W-1:0]    dec_sample;
    logic                dec_valid;
    logic [OUT_W-1:0]    pdm_ext;

    logic [OUT_W-1:0]    stage_in [ORDER];
    logic [ORDER-1:0]    stage_vld;

    assign pdm_ext = {{(OUT_W-1){1'b0}}, pdm_in};

    // Comb stage k takes its data and valid from the previous stage; stage 0 takes the decimated sample.
    // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        stage_in[0]  = dec_sample;
        stage_vld[0] = dec_valid;
        for (int k = 1; k < ORDER; k++) begin
            stage_in[k]  = comb_q[k-1];
            stage_vld[k] = comb_vld[k-1];
        end
    end

    // Integrators and decimation counter advance only on pdm_en; wrap-around is intentional.
    // NOTE: non-blocking assignments make every integrator use its pre-edge neighbour, giving the pipelined chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register arrays are cleared explicitly; a filter restart must not see stale history.
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
            cnt        <= '0;
            dec_sample <= '0;
            dec_valid  <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            if (pdm_en) begin
                integ[0] <= integ[0] + pdm_ext;
                for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    dec_sample <= integ[ORDER-1];
                    dec_valid  <= 1'b1;
                end
            end
        end
    end

    // Comb pipeline runs on every clock so it drains regardless of the strobe pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                comb_q[k] <= '0;
                comb_d[k] <= '0;
            end
            comb_vld <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                if (stage_vld[k]) begin
                    comb_q[k] <= stage_in[k] - comb_d[k];
                    comb_d[k] <= stage_in[k];
                end
            end
            comb_vld <= stage_vld;
            y_valid  <= comb_vld[ORDER-1];
            if (comb_vld[ORDER-1]) y_out <= comb_q[ORDER-1];
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: a non-pipelined reference CIC pushes
// expected samples with their due cycle into a scoreboard checked at each negedge.
module tb_cic_decimator;

    localparam int ORDER    = 4;
    localparam int DEC_LOG2 = 4;
    localparam int OUT_W    = 17;
    localparam int R        = 1 << DEC_LOG2;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pdm_en;
    logic             pdm_in;
    logic [OUT_W-1:0] y_out;
    logic             y_valid;

    always #5 clk = ~clk;

    cic_decimator #(.ORDER(ORDER), .DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .pdm_en (pdm_en),
        .pdm_in (pdm_in),
        .y_out  (y_out),
        .y_valid(y_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [OUT_W-1:0] m_int [ORDER];
    logic [OUT_W-1:0] m_d [ORDER];
    int               m_cnt;
    logic             m_event;
    exp_t             sb[$];

    // monitor state
    int               cyc = 0;
    logic [OUT_W-1:0] last_y;
    int               pulse_idx;
    int               last_pulse_cyc;
    logic             settle_on = 1'b0;
    int               settle_from = 6;
    logic [OUT_W-1:0] settle_exp;
    int               exp_period = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ORDER; k++) begin
            m_int[k] = '0;
            m_d[k]   = '0;
        end
        m_cnt     = 0;
        sb.delete();
        last_y    = '0;
        pulse_idx = 0;
    endtask

    // Reference: integrators update from pre-edge values; combs evaluated at once, result due ORDER+1 cycles later.
    task automatic model_edge(input logic r, input logic en, input logic b);
        logic [OUT_W-1:0] x, t;
        m_event = 1'b0;
        if (r) begin
            model_reset();
        end else if (en) begin
            if (m_cnt == R - 1) begin
                x = m_int[ORDER-1];
                for (int k = 0; k < ORDER; k++) begin
                    t      = x - m_d[k];
                    m_d[k] = x;
                    x      = t;
                end
                sb.push_back('{val: x, due: cyc + ORDER + 1});
                m_event = 1'b1;
            end
            for (int k = ORDER - 1; k >= 1; k--) m_int[k] = m_int[k] + m_int[k-1];
            m_int[0] = m_int[0] + {{(OUT_W-1){1'b0}}, b};
            m_cnt = (m_cnt + 1) % R;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (y_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", y_valid, 0);
            end else begin
                e = sb.pop_front();
                pulse_idx++;
                check("y_out", y_out, e.val);
                check("latency", cyc, e.due);
                if (settle_on && pulse_idx >= settle_from) check("settled", y_out, settle_exp);
                if (exp_period != 0 && pulse_idx >= 2) check("period", cyc - last_pulse_cyc, exp_period);
                last_pulse_cyc = cyc;
            end
            last_y = y_out;
        end else begin
            check("y_hold", y_out, last_y);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("missed_pulse", y_valid, 1);
                void'(sb.pop_front());
            end
        end
    endtask

    // Inputs change at negedge; the DUT samples at posedge; outputs are checked at the next negedge.
    task automatic step(input logic r, input logic en, input logic b);
        rst    = r;
        pdm_en = en;
        pdm_in = b;
        @(posedge clk);
        cyc++;
        model_edge(r, en, b);
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        logic b;
        int   n;
        rst    = 1'b1;
        pdm_en = 1'b0;
        pdm_in = 1'b0;
        model_reset();
        @(negedge clk);

        // reset state, with pdm_en high to show reset priority
        repeat (3) step(1'b1, 1'b1, 1'b1);
        check("rst_y_out", y_out, 0);
        check("rst_y_valid", y_valid, 0);

        // all ones, strobe every cycle: DC gain R^ORDER
        settle_on  = 1'b1;
        settle_exp = 17'h10000;
        exp_period = R;
        repeat (20 * R + 8) step(1'b0, 1'b1, 1'b1);

        // alternating 1,0: half-scale
        do_reset();
        settle_exp = 17'h08000;
        b = 1'b1;
        repeat (20 * R) begin
            step(1'b0, 1'b1, b);
            b = ~b;
        end

        // strobe every 4th cycle with zeros; pdm_in=1 off-strobe must be ignored
        do_reset();
        settle_exp = '0;
        exp_period = 4 * R;
        for (int i = 0; i < 12 * 4 * R; i++) step(1'b0, (i % 4) == 3, (i % 4) != 3);

        // integrator wrap: long all-ones run, then zeros must settle to exactly 0
        do_reset();
        settle_exp = 17'h10000;
        exp_period = R;
        repeat (1000) step(1'b0, 1'b1, 1'b1);
        settle_exp  = '0;
        pulse_idx   = 0;
        settle_from = 8;
        repeat (15 * R) step(1'b0, 1'b1, 1'b0);
        settle_from = 6;

        // reset one cycle after a decimation event discards it
        do_reset();
        settle_on = 1'b0;
        n = 0;
        do begin
            step(1'b0, 1'b1, 1'b1);
            n++;
        end while (!(m_event && n > 6 * R) && n < 400);
        check("found_event", m_event, 1);
        step(1'b1, 1'b0, 1'b0);
        check("midrst_y_out", y_out, 0);
        check("midrst_y_valid", y_valid, 0);
        n = 0;
        while (!y_valid && n < 200) begin
            step(1'b0, 1'b1, 1'b1);
            n++;
        end
        check("post_rst_latency", n, R + ORDER + 1);

        // random PDM, density 0.3, random strobe pattern
        do_reset();
        exp_period = 0;
        repeat (1500) step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);

        // drain and confirm nothing was left outstanding
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter ORDER, default 4: number of integrator stages and number of comb stages.
REQ-002 Parameter DEC_LOG2, default 4: log2 of decimation ratio R; R = 2^DEC_LOG2 = 16.
REQ-003 Parameter OUT_W, default 17: output and internal width; SHALL equal 1 + ORDER*DEC_LOG2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 pdm_en  input  1: PDM sample strobe; pdm_in is sampled only on edges where pdm_en=1.
REQ-007 pdm_in  input  1: microphone PDM bit; 1 maps to +1 and 0 maps to 0, zero-extended to OUT_W.
REQ-008 y_out  output  OUT_W: decimated unsigned sample; feeds the first half-band stage x_in[16:0].
REQ-009 y_valid  output  1: one-cycle pulse, high on the cycle y_out carries a new sample.

Function
REQ-010 Integrator chain SHALL be pipelined: on an edge with pdm_en=1, I1 <= I1 + pdm_in and Ik <= Ik + I(k-1) for k=2..ORDER, using pre-edge register values.
REQ-011 Integrators SHALL use modulo-2^OUT_W wrap-around arithmetic with no saturation; wrap SHALL NOT corrupt output (Hogenauer property).
REQ-012 Decimation counter SHALL be DEC_LOG2 bits, increment by 1 on each pdm_en=1 edge, and wrap from R-1 to 0.
REQ-013 Decimation event: an edge with pdm_en=1 and counter=R-1; on that edge dec_sample <= I_ORDER (pre-edge value) and comb-valid stage 0 is set.
REQ-014 Comb chain SHALL have ORDER registered stages; stage k, when its input valid is high: Ck <= in_k - Dk, Dk <= in_k, valid(k) <= 1; otherwise Ck and Dk hold and valid(k) <= 0.
REQ-015 Comb arithmetic SHALL be OUT_W-bit modulo subtraction.
REQ-016 Latency: y_out <= C_ORDER and y_valid=1 exactly ORDER+1 clk cycles after the decimation-event edge; y_valid is high for exactly one cycle.
REQ-017 y_out SHALL hold its value between y_valid pulses.
REQ-018 With pdm_en=0 the integrators and counter SHALL hold; comb pipeline SHALL continue draining independently.
REQ-019 Combs run on clk, not on pdm_en; any pdm_en pattern, including pdm_en held at 1, SHALL produce exactly one y_valid per R pdm_en strobes.
REQ-020 DC gain SHALL be R^ORDER = 65536: settled all-ones input gives y_out=0x10000; all-zeros gives 0.
REQ-021 The first ORDER+1 outputs after reset are transient; outputs from the 6th y_valid onward SHALL be settled values.

Reset
REQ-022 On an edge with rst=1, all integrators, comb registers, comb delays, dec_sample, counter, valid pipeline, y_out and y_valid SHALL clear to 0.
REQ-023 rst SHALL take priority over pdm_en on the same edge.
REQ-024 rst mid-operation SHALL discard in-flight samples; no y_valid SHALL appear from pre-reset data.
REQ-025 The first post-reset decimation event SHALL occur on the R-th pdm_en=1 edge after rst deasserts.

Verification
REQ-026 rst, then pdm_en=1 every cycle, pdm_in=1 -> y_valid every 16 cycles; y_out=0x10000 from the 6th pulse onward.
REQ-027 pdm_en=1 every cycle, pdm_in alternating 1,0 -> settled y_out=0x08000 (32768).
REQ-028 pdm_en=1 every 4th cycle, pdm_in=0 -> y_valid every 64 cycles; y_out=0; pulse width 1 cycle.
REQ-029 Run all-ones for 1000 cycles so integrators wrap, then switch to all-zeros -> y_out returns to exactly 0 after settling; no spurious values once settled.
REQ-030 Assert rst one cycle after a decimation event -> no y_valid for that event; all outputs 0; next y_valid occurs 16 pdm_en strobes + ORDER+1 cycles after rst deasserts.
REQ-031 Random PDM stream (density 0.3) compared sample-by-sample against a bit-exact reference model of REQ-010..REQ-016 -> zero mismatches.
